// File: rtl/sync_fifo_lvl.sv
// Single-clock FIFO using all 2**AW entries, with a fill-level output, programmable
// almost-full/almost-empty, sticky overflow/underflow, synchronous flush and optional FWFT read.
module sync_fifo_lvl #(
  parameter int DW        = 8,
  parameter int AW        = 4,
  parameter bit FWFT      = 1'b0,
  parameter int AF_THRESH = (2**AW) - 1,
  parameter int AE_THRESH = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush_i,
  input  logic          clr_flags_i,
  input  logic          wr_en_i,
  input  logic [DW-1:0] wr_data_i,
  input  logic          rd_en_i,
  output logic [DW-1:0] rd_data_o,
  output logic          full_o,
  output logic          empty_o,
  output logic          almost_full_o,
  output logic          almost_empty_o,
  output logic [AW:0]   level_o,
  output logic          overflow_o,
  output logic          underflow_o
);

  localparam int            DEPTH   = 2**AW;
  localparam logic [AW:0]   DEPTH_L = (AW+1)'(DEPTH);
  localparam logic [AW:0]   AF_L    = (AW+1)'(AF_THRESH);
  localparam logic [AW:0]   AE_L    = (AW+1)'(AE_THRESH);
  localparam logic [AW:0]   LVL_ONE = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   level;
  logic          do_rd, do_wr;
  logic          wr_accept, rd_accept;
  logic          ovf_q, udf_q;

  // Handshake: a read is taken when requested and not empty; a write is taken when
  // requested and there is room, where a simultaneous read frees the slot of a full FIFO.
  assign do_rd     = rd_en_i & ~empty_o;
  assign do_wr     = wr_en_i & (~full_o | do_rd);
  assign wr_accept = do_wr & ~flush_i;
  assign rd_accept = do_rd & ~flush_i;

  assign full_o         = (level == DEPTH_L);
  assign empty_o        = (level == '0);
  assign almost_full_o  = (level >= AF_L);
  assign almost_empty_o = (level <= AE_L);
  assign level_o        = level;
  assign overflow_o     = ovf_q;
  assign underflow_o    = udf_q;

  // Storage has no reset so it can map onto block RAM.
  always_ff @(posedge clk) begin
    if (wr_accept) mem[wr_ptr] <= wr_data_i;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      ovf_q  <= 1'b0;
      udf_q  <= 1'b0;
    end else begin
      if (flush_i) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        level  <= '0;
      end else begin
        if (wr_accept) wr_ptr <= wr_ptr + PTR_ONE;
        if (rd_accept) rd_ptr <= rd_ptr + PTR_ONE;
        case ({do_wr, do_rd})
          2'b10:   level <= level + LVL_ONE;
          2'b01:   level <= level - LVL_ONE;
          default: level <= level;
        endcase
      end
      // A new event outranks a clear arriving in the same cycle; flushed requests raise nothing.
      ovf_q <= (ovf_q & ~clr_flags_i) | (~flush_i & wr_en_i & ~do_wr);
      udf_q <= (udf_q & ~clr_flags_i) | (~flush_i & rd_en_i & empty_o);
    end
  end

  generate
    if (FWFT) begin : g_fwft
      assign rd_data_o = mem[rd_ptr];
    end else begin : g_reg
      logic [DW-1:0] rd_q;
      always_ff @(posedge clk) begin
        if (rst)            rd_q <= '0;
        else if (rd_accept) rd_q <= mem[rd_ptr];
      end
      assign rd_data_o = rd_q;
    end
  endgenerate

endmodule

// File: tb/tb_sync_fifo_lvl.sv
// Directed bench for sync_fifo_lvl: three instances (AW=2 registered, AW=2 FWFT, AW=3 thresholds)
// driven from one table of hand-computed vectors plus a hand-written reset sequence.
module tb_sync_fifo_lvl;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] flush, clrf, wr_en, rd_en;
  logic [7:0] wd  [3];
  logic [7:0] rdd [3];
  logic [2:0] full, empty, af, ae, ovf, udf;
  logic [2:0] lvl0, lvl1;
  logic [3:0] lvl2;

  always #5 clk = ~clk;

  sync_fifo_lvl #(.DW(8), .AW(2), .FWFT(1'b0)) u0 (
    .clk(clk), .rst(rst), .flush_i(flush[0]), .clr_flags_i(clrf[0]),
    .wr_en_i(wr_en[0]), .wr_data_i(wd[0]), .rd_en_i(rd_en[0]), .rd_data_o(rdd[0]),
    .full_o(full[0]), .empty_o(empty[0]), .almost_full_o(af[0]), .almost_empty_o(ae[0]),
    .level_o(lvl0), .overflow_o(ovf[0]), .underflow_o(udf[0]));

  sync_fifo_lvl #(.DW(8), .AW(2), .FWFT(1'b1)) u1 (
    .clk(clk), .rst(rst), .flush_i(flush[1]), .clr_flags_i(clrf[1]),
    .wr_en_i(wr_en[1]), .wr_data_i(wd[1]), .rd_en_i(rd_en[1]), .rd_data_o(rdd[1]),
    .full_o(full[1]), .empty_o(empty[1]), .almost_full_o(af[1]), .almost_empty_o(ae[1]),
    .level_o(lvl1), .overflow_o(ovf[1]), .underflow_o(udf[1]));

  sync_fifo_lvl #(.DW(8), .AW(3), .FWFT(1'b0), .AF_THRESH(6), .AE_THRESH(2)) u2 (
    .clk(clk), .rst(rst), .flush_i(flush[2]), .clr_flags_i(clrf[2]),
    .wr_en_i(wr_en[2]), .wr_data_i(wd[2]), .rd_en_i(rd_en[2]), .rd_data_o(rdd[2]),
    .full_o(full[2]), .empty_o(empty[2]), .almost_full_o(af[2]), .almost_empty_o(ae[2]),
    .level_o(lvl2), .overflow_o(ovf[2]), .underflow_o(udf[2]));

  typedef struct {
    int inst;
    int wr;
    int wd;
    int rd;
    int fl;
    int clr;
    int lvl;
    int ovf;
    int udf;
    int chk_d;
    int d;
  } vec_t;

  vec_t vecs[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  function automatic void add(int inst, int wr, int wdat, int rd, int fl, int clr,
                              int lvl, int o, int u, int chk, int d);
    vec_t v;
    v.inst = inst; v.wr = wr; v.wd = wdat; v.rd = rd; v.fl = fl; v.clr = clr;
    v.lvl = lvl; v.ovf = o; v.udf = u; v.chk_d = chk; v.d = d;
    vecs.push_back(v);
  endfunction

  task automatic idle();
    flush = '0; clrf = '0; wr_en = '0; rd_en = '0;
    for (int i = 0; i < 3; i++) wd[i] = 8'h00;
  endtask

  task automatic check(input string name, input int idx, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s step %0d: got 0x%0h, expected 0x%0h", name, idx, got, exp);
    end
  endtask

  function automatic int get_lvl(int i);
    case (i)
      0:       return int'(lvl0);
      1:       return int'(lvl1);
      default: return int'(lvl2);
    endcase
  endfunction

  // Flag decodes are derived from the expected level using each instance's own thresholds.
  task automatic check_inst(input int idx, input int i, input int lvl, input int o,
                            input int u, input int chk, input int d);
    int depth, af_t, ae_t;
    depth = (i == 2) ? 8 : 4;
    af_t  = (i == 2) ? 6 : 3;
    ae_t  = (i == 2) ? 2 : 1;
    check($sformatf("level[%0d]", i), idx, get_lvl(i), lvl);
    check($sformatf("full[%0d]", i), idx, int'(full[i]), (lvl == depth) ? 1 : 0);
    check($sformatf("empty[%0d]", i), idx, int'(empty[i]), (lvl == 0) ? 1 : 0);
    check($sformatf("almost_full[%0d]", i), idx, int'(af[i]), (lvl >= af_t) ? 1 : 0);
    check($sformatf("almost_empty[%0d]", i), idx, int'(ae[i]), (lvl <= ae_t) ? 1 : 0);
    check($sformatf("overflow[%0d]", i), idx, int'(ovf[i]), o);
    check($sformatf("underflow[%0d]", i), idx, int'(udf[i]), u);
    if (chk != 0) check($sformatf("rd_data[%0d]", i), idx, int'(rdd[i]), d);
  endtask

  initial begin
    vec_t v;
    idle();
    rst = 1'b1;

    // Fill/drain with overflow, registered read data one cycle after each accepted read.
    add(0, 1, 'hA0, 0, 0, 0, 1, 0, 0, 0, 0);
    add(0, 1, 'hA1, 0, 0, 0, 2, 0, 0, 0, 0);
    add(0, 1, 'hA2, 0, 0, 0, 3, 0, 0, 0, 0);
    add(0, 1, 'hA3, 0, 0, 0, 4, 0, 0, 0, 0);
    add(0, 1, 'hA4, 0, 0, 0, 4, 1, 0, 0, 0);
    add(0, 0, 0, 1, 0, 0, 3, 1, 0, 1, 'hA0);
    add(0, 0, 0, 1, 0, 0, 2, 1, 0, 1, 'hA1);
    add(0, 0, 0, 1, 0, 0, 1, 1, 0, 1, 'hA2);
    add(0, 0, 0, 1, 0, 0, 0, 1, 0, 1, 'hA3);
    add(0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 'hA3);
    // Pointer wrap-around.
    for (int i = 0; i < 3; i++) add(0, 1, i + 1, 0, 0, 0, i + 1, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) add(0, 0, 0, 1, 0, 0, 2 - i, 0, 0, 1, i + 1);
    for (int i = 0; i < 3; i++) add(0, 1, 'h10 + i, 0, 0, 0, i + 1, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) add(0, 0, 0, 1, 0, 0, 2 - i, 0, 0, 1, 'h10 + i);
    // Simultaneous read/write when full, then when empty; set beats clear.
    for (int i = 0; i < 4; i++) add(0, 1, 'h20 + i, 0, 0, 0, i + 1, 0, 0, 0, 0);
    add(0, 1, 'h24, 1, 0, 0, 4, 0, 0, 1, 'h20);
    for (int i = 0; i < 4; i++) add(0, 0, 0, 1, 0, 0, 3 - i, 0, 0, 1, 'h21 + i);
    add(0, 1, 'h30, 1, 0, 0, 1, 0, 1, 1, 'h24);
    add(0, 0, 0, 1, 0, 0, 0, 0, 1, 1, 'h30);
    add(0, 0, 0, 1, 0, 1, 0, 0, 1, 1, 'h30);
    add(0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 'h30);
    // First-word-fall-through head visibility.
    add(1, 1, 'h5A, 0, 0, 0, 1, 0, 0, 1, 'h5A);
    add(1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
    add(1, 1, 'h5B, 0, 0, 0, 1, 0, 0, 1, 'h5B);
    add(1, 1, 'h5C, 0, 0, 0, 2, 0, 0, 1, 'h5B);
    add(1, 0, 0, 1, 0, 0, 1, 0, 0, 1, 'h5C);
    add(1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
    add(1, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0);
    // Thresholds at AW=3 (AF=6, AE=2), flush with requests, refill after flush.
    for (int i = 0; i < 6; i++) add(2, 1, i + 1, 0, 0, 0, i + 1, 0, 0, 0, 0);
    add(2, 0, 0, 1, 0, 0, 5, 0, 0, 1, 'h01);
    add(2, 1, 'h99, 1, 1, 0, 0, 0, 0, 1, 'h01);
    for (int i = 0; i < 8; i++) add(2, 1, 'h70 + i, 0, 0, 0, i + 1, 0, 0, 0, 0);
    add(2, 1, 'h78, 0, 0, 0, 8, 1, 0, 0, 0);
    add(2, 0, 0, 1, 0, 0, 7, 1, 0, 1, 'h70);

    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check_inst(-1, 0, 0, 0, 0, 1, 0);
    check_inst(-1, 1, 0, 0, 0, 0, 0);
    check_inst(-1, 2, 0, 0, 0, 1, 0);

    for (int k = 0; k < vecs.size(); k++) begin
      v = vecs[k];
      idle();
      wr_en[v.inst] = v.wr[0];
      wd[v.inst]    = v.wd[7:0];
      rd_en[v.inst] = v.rd[0];
      flush[v.inst] = v.fl[0];
      clrf[v.inst]  = v.clr[0];
      @(posedge clk);
      #1;
      check_inst(k, v.inst, v.lvl, v.ovf, v.udf, v.chk_d, v.d);
    end

    // Reset in the middle of traffic discards all state in one edge.
    idle();
    wr_en[2] = 1'b1; wd[2] = 8'hEE;
    rd_en[1] = 1'b1;
    wr_en[0] = 1'b1; wd[0] = 8'hEF;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle();
    check_inst(1000, 0, 0, 0, 0, 1, 0);
    check_inst(1000, 1, 0, 0, 0, 0, 0);
    check_inst(1000, 2, 0, 0, 0, 1, 0);

    // Pointers restart at zero after reset.
    wr_en[2] = 1'b1; wd[2] = 8'h42;
    @(posedge clk);
    #1;
    idle();
    rd_en[2] = 1'b1;
    @(posedge clk);
    #1;
    idle();
    check_inst(1001, 2, 0, 0, 0, 1, 'h42);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
